// File: rtl/m_multiplier_seq_if.sv
// Request/response bundle between the execute stage and the iterative RV32M multiplier.
// The master side is the execute stage; the slave side is m_multiplier_seq.
interface m_multiplier_seq_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic [1:0]  sel;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] rd;
  logic        busy;

  modport master (
    output in_valid, rs1, rs2, sel, out_ready,
    input  in_ready, out_valid, rd, busy
  );

  modport slave (
    input  in_valid, rs1, rs2, sel, out_ready,
    output in_ready, out_valid, rd, busy
  );
endinterface

// File: rtl/m_multiplier_seq.sv
// Iterative shift-add RV32M multiplier (MUL/MULH/MULHSU/MULHU), one multiplier bit per cycle.
// Optional macro M_MUL_EARLY_OUT_EN ends the RUN phase once the remaining multiplier bits are zero.
module m_multiplier_seq (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  m_multiplier_seq_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_SIGN = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t      state_r;
  state_t      state_s;
  logic [1:0]  sel_r;
  logic [63:0] mcand_r;
  logic [31:0] mplier_r;
  logic [63:0] acc_r;
  logic [4:0]  cnt_r;
  logic        neg_r;
  logic [31:0] rd_r;

  logic        accept_s;
  logic        rs1_signed_s;
  logic        rs2_signed_s;
  logic [31:0] mplier_shift_s;
  logic        run_last_s;
  logic [63:0] final_s;

  // |v| of a two's-complement word; 0x80000000 maps to itself, read as unsigned
  function automatic logic [31:0] abs32(input logic [31:0] v);
    logic [31:0] r;
    if (v[31]) begin
      r = ~v + 32'd1;
    end else begin
      r = v;
    end
    return r;
  endfunction

  assign accept_s       = bus.in_valid & bus.in_ready & ~flush;
  assign rs1_signed_s   = (bus.sel == 2'b01) || (bus.sel == 2'b10);
  assign rs2_signed_s   = (bus.sel == 2'b01);
  assign mplier_shift_s = mplier_r >> 1;
  assign final_s        = neg_r ? (~acc_r + 64'd1) : acc_r;

`ifdef M_MUL_EARLY_OUT_EN
  assign run_last_s = (cnt_r == 5'd31) || (mplier_shift_s == 32'd0);
`else
  assign run_last_s = (cnt_r == 5'd31);
`endif

  assign bus.in_ready  = (state_r == ST_IDLE);
  assign bus.out_valid = (state_r == ST_DONE);
  assign bus.busy      = (state_r != ST_IDLE);
  assign bus.rd        = rd_r;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; flush kills whatever is in flight
  always_comb begin
    state_s = state_r;
    if (flush) begin
      state_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            state_s = ST_RUN;
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_RUN: begin
          if (run_last_s) begin
            state_s = ST_SIGN;
          end else begin
            state_s = ST_RUN;
          end
        end
        ST_SIGN: begin
          state_s = ST_DONE;
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            state_s = ST_IDLE;
          end else begin
            state_s = ST_DONE;
          end
        end
        default: begin
          state_s = ST_IDLE;
        end
      endcase
    end
  end

  // Datapath: operand capture, shift-add iterations, sign fix-up and result latch
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sel_r    <= 2'b00;
      mcand_r  <= 64'd0;
      mplier_r <= 32'd0;
      acc_r    <= 64'd0;
      cnt_r    <= 5'd0;
      neg_r    <= 1'b0;
      rd_r     <= 32'd0;
    end else if (!flush) begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            sel_r    <= bus.sel;
            mcand_r  <= {32'd0, rs1_signed_s ? abs32(bus.rs1) : bus.rs1};
            mplier_r <= rs2_signed_s ? abs32(bus.rs2) : bus.rs2;
            neg_r    <= (bus.rs1[31] & rs1_signed_s) ^ (bus.rs2[31] & rs2_signed_s);
            acc_r    <= 64'd0;
            cnt_r    <= 5'd0;
          end
        end
        ST_RUN: begin
          if (mplier_r[0]) begin
            acc_r <= acc_r + mcand_r;
          end
          mcand_r  <= mcand_r << 1;
          mplier_r <= mplier_shift_s;
          cnt_r    <= cnt_r + 5'd1;
        end
        ST_SIGN: begin
          acc_r <= final_s;
          rd_r  <= (sel_r == 2'b00) ? final_s[31:0] : final_s[63:32];
        end
        ST_DONE: begin
          rd_r <= rd_r;
        end
        default: begin
          rd_r <= rd_r;
        end
      endcase
    end
  end

endmodule

// File: doc/m_multiplier_seq.md
# m_multiplier_seq

Iterative RV32M multiplier for the M-extension execute stage. It implements MUL, MULH, MULHSU and MULHU with a shift-add datapath that processes one multiplier bit per cycle. Operands are accepted through a valid/ready handshake, and the result is held on a valid/ready output port. The execute stage stalls on `in_ready`/`out_valid`, and `flush` discards an in-flight operation on a pipeline kill.

## Interface
- No parameters; fixed at XLEN = 32.
- `clk` input 1 — single clock, rising edge.
- `rst_n` input 1 — synchronous, active-low reset.
- `flush` input 1 — synchronous kill of any operation in progress.
- `in_valid` input 1 — operation request.
- `in_ready` output 1 — high only in IDLE; combinational from state.
- `rs1` input 32 — multiplicand operand.
- `rs2` input 32 — multiplier operand.
- `sel` input 2 — operation select: 00 MUL (low 32 bits), 01 MULH (signed×signed, high), 10 MULHSU (signed rs1 × unsigned rs2, high), 11 MULHU (unsigned×unsigned, high).
- `out_valid` output 1 — result available.
- `out_ready` input 1 — consumer accepts the result.
- `rd` output 32 — result.
- `busy` output 1 — high in RUN, SIGN or DONE.

## Operation
- **States:** IDLE, RUN, SIGN, DONE.
- **Accept:** accept = `in_valid & in_ready & ~flush`. On accept, the block registers the following and moves to RUN:
  - `sel`.
  - Multiplicand `mcand` = 64-bit zero-extended |rs1| if rs1 is treated as signed, otherwise rs1.
  - Multiplier `mplier` = |rs2| if rs2 is treated as signed, otherwise rs2.
  - `neg` = (rs1[31] & rs1 signed) ^ (rs2[31] & rs2 signed).
  - `acc` = 0 and `cnt` = 0.
- **Signedness:** MUL treats both operands as unsigned, since the low 32 bits are identical either way. |0x80000000| = 0x80000000, interpreted as unsigned.
- **RUN, each cycle:**
  - If `mplier[0]`, then `acc += mcand` (64-bit, no overflow possible).
  - `mcand <<= 1`, `mplier >>= 1`, `cnt++`.
  - Move to SIGN after the 32nd iteration (`cnt` == 31 at the edge).
- **SIGN:** if `neg`, `acc = ~acc + 1` (64-bit). Move to DONE.
- **DONE:**
  - `rd` = `acc[31:0]` for MUL, otherwise `acc[63:32]`. `rd` is registered and stable while `out_valid` is high.
  - On `out_valid & out_ready`, move to IDLE.
- **flush (any state):** next state IDLE and `out_valid` = 0. The result is discarded and `rd` is left unchanged. Flush in IDLE while `in_valid` is high means no accept.
- **Reset (any state, including mid-RUN):** IDLE, `in_ready` = 1, `out_valid` = 0, `busy` = 0, `rd` = 0, all internal registers = 0. Reset has priority over flush.
- **Back-to-back operations:** a new operation is accepted only in IDLE. There is one bubble cycle after each result handshake.

## Timing
- The accept edge is E0. RUN edges are E1..E32. The SIGN edge is E33. `out_valid` is high after E33, giving 33 cycles from accept to result.
- `out_valid` stays high, and `rd` is held, for as many cycles as `out_ready` stays low.
- If `out_ready` is high in the first DONE cycle, the handshake completes and `in_ready` is high after the next edge.
- `in_ready` is low from after E0 until the cycle after the result handshake.

## Configuration
- **`M_MUL_EARLY_OUT_EN` defined:**
  - RUN also ends when the post-shift `mplier` is zero.
  - Iteration count N = max(1, index of highest set bit of the registered multiplier + 1).
  - `out_valid` is high after E(N+1). Example: rs2 = 3 gives N = 2, so `out_valid` after E3. Multiplier 0 gives N = 1, so `out_valid` after E2.
- **Not defined:** fixed 32 iterations and a latency of 33 cycles, independent of data.
- Results are identical in both builds.

## Test plan
- **MUL:** rs1 = 7, rs2 = 0xFFFFFFFD -> `rd` = 0xFFFFFFEB. `out_valid` after exactly 33 edges (macro off).
- **MULH / MULHU:**
  - MULH 0x80000000 × 0x80000000 -> 0x40000000.
  - MULHU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFE.
- **MULHSU:** rs1 = 0xFFFFFFFF, rs2 = 0xFFFFFFFF -> 0xFFFFFFFF. MULHSU 2 × 0x80000000 -> 0x00000001.
- **Backpressure and handshake:**
  - Hold `out_ready` = 0 for 10 cycles -> `out_valid` and `rd` stay stable, and `in_ready` stays 0.
  - `in_valid` asserted during RUN is not accepted.
- **Flush and reset:**
  - `flush` at E10 of RUN -> IDLE next edge, no `out_valid`, and a subsequent MUL 6 × 7 returns 42.
  - `rst_n` = 0 mid-RUN -> all outputs reach their reset values at the next edge.
  - `flush` together with `in_valid` in IDLE -> no accept.
- **Early-out (`M_MUL_EARLY_OUT_EN`):**
  - MUL 5 × 3 -> 15 with `out_valid` after E3.
  - MULHU with rs2 = 0xFFFFFFFF -> 33 cycles.
  - rs2 = 0 -> `rd` = 0 after E2.
